// File: rtl/glb_arb_pkg.sv
// Shared constants and helpers for the global-buffer port arbiter and its
// sibling sequencers.
package glb_arb_pkg;

   localparam int REQ_IFMAP  = 0;
   localparam int REQ_FILTER = 1;
   localparam int REQ_IPSUM  = 2;
   localparam int REQ_OPSUM  = 3;

   localparam logic [3:0] WE_FULL = 4'hF;

   // Lowest bit of agent idx's address field inside a packed address bus.
   function automatic int addr_lsb(input int idx, input int addr_w);
      return idx * addr_w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i,
// wrapping modulo N, returned one-hot and as an index.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      // NOTE: outputs get defaults before any branch so no path leaves them
      // unassigned; otherwise synthesis infers latches.
      gnt_o = '0;
      idx_o = '0;
      // Walk from farthest to nearest so the candidate closest to start_i is
      // the last one written and therefore wins.
      for (int k = N - 1; k >= 0; k--) begin
         int j;
         j = (int'(start_i) + k) % N;
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/glb_port_arbiter.sv
// Shares the single global-buffer BRAM port among the ifmap, filter, ipsum
// and opsum agents: bounded-burst round robin, registered command, tagged returns.
module glb_port_arbiter
   import glb_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int BURST_LEN    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      ram_enable,
   output logic [3:0]                ram_we,
   output logic [ADDR_W-1:0]         ram_address,
   output logic [DATA_W-1:0]         ram_wdata,
   input  logic [DATA_W-1:0]         ram_rdata,
   output logic                      busy
);

   localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW   = $clog2(BURST_LEN) + 1;
   localparam int NSTG = READ_LATENCY + 1;

   logic [IW-1:0]      owner_q, owner_d;
   logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
   logic               cmd_en_q, cmd_en_d;
   logic [3:0]         cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0]  cmd_wdata_q, cmd_wdata_d;
   logic [NUM_REQ-1:0] tag_q [NSTG];
   logic [NUM_REQ-1:0] tag_d;

   logic [NUM_REQ-1:0] owner_oh, pick_gnt, gnt_c;
   logic [IW-1:0]      pick_idx, gnt_idx, start_ptr;
   logic               keep_owner, gnt_any, burst_open;

   assign owner_oh   = NUM_REQ'(1) << owner_q;
   assign start_ptr  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign burst_open = int'(burst_cnt_q) < BURST_LEN - 1;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req_i   (req),
      .start_i (start_ptr),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx)
   );

   always_comb begin
      // The owner keeps the port while its burst lasts or nobody else waits.
      keep_owner  = req[owner_q] && (burst_open || ((req & ~owner_oh) == '0));
      gnt_any     = |req;
      gnt_c       = keep_owner ? owner_oh : pick_gnt;
      gnt_idx     = keep_owner ? owner_q : pick_idx;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      if (gnt_any) begin
         if (gnt_idx == owner_q) begin
            if (burst_open) burst_cnt_d = burst_cnt_q + 1'b1;
         end else begin
            owner_d     = gnt_idx;
            burst_cnt_d = '0;
         end
      end
   end

   always_comb begin
      cmd_en_d    = gnt_any;
      cmd_we_d    = '0;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      tag_d       = '0;
      if (gnt_any) begin
         cmd_addr_d = req_addr[addr_lsb(int'(gnt_idx), ADDR_W) +: ADDR_W];
         if (gnt_c[REQ_OPSUM]) begin
            cmd_we_d    = WE_FULL;
            cmd_wdata_d = wr_data;
         end else begin
            tag_d = gnt_c;
         end
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values
   // regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q     <= '0;
         burst_cnt_q <= '0;
         cmd_en_q    <= 1'b0;
         cmd_we_q    <= '0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         // NOTE: the tag stages are control state, not data storage, so every
         // stage is reset; a surviving tag would fire rd_valid after reset.
         for (int s = 0; s < NSTG; s++) tag_q[s] <= '0;
      end else begin
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         cmd_en_q    <= cmd_en_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         tag_q[0]    <= tag_d;
         for (int s = 1; s < NSTG; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < NSTG; s++) busy = busy | (|tag_q[s]);
   end

   assign gnt         = rst ? gnt_c : '0;
   assign ram_enable  = cmd_en_q;
   assign ram_we      = cmd_we_q;
   assign ram_address = cmd_addr_q;
   assign ram_wdata   = cmd_wdata_q;
   assign rd_valid    = tag_q[READ_LATENCY];
   assign rd_data     = (|rd_valid) ? ram_rdata : '0;

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Scoreboard bench for glb_port_arbiter: instance 0 uses BURST_LEN=4/READ_LATENCY=1,
// instance 1 uses BURST_LEN=1/READ_LATENCY=3.
module tb_glb_port_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [3:0]    we;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [NR-1:0] tag;
      logic [DW-1:0] data;
   } rd_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n       [2];
   logic [NR-1:0]    req         [2];
   logic [NR*AW-1:0] req_addr    [2];
   logic [DW-1:0]    wr_data     [2];
   logic [NR-1:0]    gnt         [2];
   logic [NR-1:0]    rd_valid    [2];
   logic [DW-1:0]    rd_data     [2];
   logic             ram_enable  [2];
   logic [3:0]       ram_we      [2];
   logic [AW-1:0]    ram_address [2];
   logic [DW-1:0]    ram_wdata   [2];
   logic [DW-1:0]    ram_rdata   [2];
   logic             busy        [2];

   logic [NR-1:0] gnt_q [2][$];
   cmd_t          cmd_q [2][$];
   rd_t           rd_q  [2][$];

   int   n_checks = 0;
   int   n_errors = 0;
   cmd_t mon_cmd;
   rd_t  mon_rd;

   glb_port_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .BURST_LEN(4)
   ) u_dut_a (
      .clk(clk), .rst(rst_n[0]), .req(req[0]), .req_addr(req_addr[0]),
      .wr_data(wr_data[0]), .gnt(gnt[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
      .ram_enable(ram_enable[0]), .ram_we(ram_we[0]), .ram_address(ram_address[0]),
      .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]), .busy(busy[0])
   );

   glb_port_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3), .BURST_LEN(1)
   ) u_dut_b (
      .clk(clk), .rst(rst_n[1]), .req(req[1]), .req_addr(req_addr[1]),
      .wr_data(wr_data[1]), .gnt(gnt[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
      .ram_enable(ram_enable[1]), .ram_we(ram_we[1]), .ram_address(ram_address[1]),
      .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]), .busy(busy[1])
   );

   // BRAM content is a fixed function of the address, so reads need no preload.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   logic [DW-1:0] pipe_a;
   logic [DW-1:0] pipe_b [3];

   always @(posedge clk) begin
      pipe_a    <= (ram_enable[0] && ram_we[0] == 4'h0) ? mem_word(ram_address[0]) : '0;
      pipe_b[0] <= (ram_enable[1] && ram_we[1] == 4'h0) ? mem_word(ram_address[1]) : '0;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end

   assign ram_rdata[0] = pipe_a;
   assign ram_rdata[1] = pipe_b[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever a DUT presents a grant, command or return.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (gnt[d] != '0) begin
            if (gnt_q[d].size() == 0) check($sformatf("gnt%0d_unexpected", d), 64'(gnt[d]), 64'(0));
            else check($sformatf("gnt%0d", d), 64'(gnt[d]), 64'(gnt_q[d].pop_front()));
         end
         if (ram_enable[d]) begin
            if (cmd_q[d].size() == 0) begin
               check($sformatf("cmd%0d_unexpected", d), 64'(ram_enable[d]), 64'(0));
            end else begin
               mon_cmd = cmd_q[d].pop_front();
               check($sformatf("cmd%0d_addr", d), 64'(ram_address[d]), 64'(mon_cmd.addr));
               check($sformatf("cmd%0d_we", d), 64'(ram_we[d]), 64'(mon_cmd.we));
               if (mon_cmd.we != 4'h0)
                  check($sformatf("cmd%0d_wdata", d), 64'(ram_wdata[d]), 64'(mon_cmd.wdata));
            end
         end
         if (rd_valid[d] != '0) begin
            if (rd_q[d].size() == 0) begin
               check($sformatf("rd%0d_unexpected", d), 64'(rd_valid[d]), 64'(0));
            end else begin
               mon_rd = rd_q[d].pop_front();
               check($sformatf("rd%0d_tag", d), 64'(rd_valid[d]), 64'(mon_rd.tag));
               check($sformatf("rd%0d_data", d), 64'(rd_data[d]), 64'(mon_rd.data));
            end
         end
      end
   end

   task automatic set_addr(input int d, input int i, input logic [AW-1:0] a);
      req_addr[d][i*AW +: AW] = a;
   endtask

   // One cycle of stimulus; eg is the hand-computed grant for this cycle.
   task automatic step(input int d, input logic [NR-1:0] r, input logic [NR-1:0] eg);
      logic [AW-1:0] a;
      int            idx;
      req[d] = r;
      if (eg != '0) begin
         idx = 0;
         for (int i = 0; i < NR; i++) if (eg[i]) idx = i;
         a = req_addr[d][idx*AW +: AW];
         gnt_q[d].push_back(eg);
         cmd_q[d].push_back('{addr: a, we: eg[3] ? 4'hF : 4'h0, wdata: eg[3] ? wr_data[d] : '0});
         if (!eg[3]) rd_q[d].push_back('{tag: eg, data: mem_word(a)});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input int d, input string tag);
      check($sformatf("%s_gnt", tag), 64'(gnt[d]), 64'(0));
      check($sformatf("%s_rd_valid", tag), 64'(rd_valid[d]), 64'(0));
      check($sformatf("%s_rd_data", tag), 64'(rd_data[d]), 64'(0));
      check($sformatf("%s_ram_enable", tag), 64'(ram_enable[d]), 64'(0));
      check($sformatf("%s_ram_we", tag), 64'(ram_we[d]), 64'(0));
      check($sformatf("%s_ram_address", tag), 64'(ram_address[d]), 64'(0));
      check($sformatf("%s_ram_wdata", tag), 64'(ram_wdata[d]), 64'(0));
      check($sformatf("%s_busy", tag), 64'(busy[d]), 64'(0));
   endtask

   logic [NR-1:0] a3_gnt [10];
   logic [NR-1:0] b2_gnt [8];

   initial begin
      a3_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
      b2_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int d = 0; d < 2; d++) begin
         rst_n[d]    = 1'b1;
         req[d]      = '0;
         req_addr[d] = '0;
         wr_data[d]  = '0;
      end
      #2;
      rst_n[0] = 1'b0;
      rst_n[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet(0, "reset_a");
      check_quiet(1, "reset_b");
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(posedge clk);
      #1;

      // Single ifmap reader held three cycles.
      set_addr(0, 0, 32'h10);
      step(0, 4'b0001, 4'b0001);
      check("a1_cmd_latency", 64'(ram_enable[0]), 64'(1));
      check("a1_no_early_rd", 64'(rd_valid[0]), 64'(0));
      step(0, 4'b0001, 4'b0001);
      check("a1_rd_latency", 64'(rd_valid[0]), 64'(4'b0001));
      step(0, 4'b0001, 4'b0001);
      step(0, 4'b0000, 4'b0000);

      // Lone ipsum reader keeps the port past the burst limit.
      for (int k = 0; k < 10; k++) begin
         set_addr(0, 2, 32'h100 + 32'(4 * k));
         step(0, 4'b0100, 4'b0100);
      end
      step(0, 4'b0000, 4'b0000);

      // Two readers contending with bursts of four.
      set_addr(0, 0, 32'h200);
      set_addr(0, 1, 32'h300);
      for (int k = 0; k < 10; k++) step(0, 4'b0011, a3_gnt[k]);
      step(0, 4'b0000, 4'b0000);

      // Opsum write: command carries data and byte enables, no return.
      set_addr(1, 3, 32'h40);
      wr_data[1] = 32'hDEADBEEF;
      step(1, 4'b1000, 4'b1000);
      step(1, 4'b0000, 4'b0000);

      // Strict round robin with all four agents requesting.
      set_addr(1, 0, 32'h10);
      set_addr(1, 1, 32'h20);
      set_addr(1, 2, 32'h30);
      set_addr(1, 3, 32'h44);
      wr_data[1] = 32'h1234_5678;
      for (int k = 0; k < 8; k++) begin
         step(1, 4'b1111, b2_gnt[k]);
         if (k == 3) check("b2_rd_latency", 64'(rd_valid[1]), 64'(4'b0001));
      end
      step(1, 4'b0000, 4'b0000);
      repeat (5) @(posedge clk);
      #1;

      // Reads in flight, then reset before they return.
      set_addr(1, 0, 32'h50);
      set_addr(1, 1, 32'h60);
      step(1, 4'b0111, 4'b0001);
      step(1, 4'b0110, 4'b0010);
      step(1, 4'b0000, 4'b0000);
      check("b3_busy_in_flight", 64'(busy[1]), 64'(1));
      rst_n[1] = 1'b0;
      gnt_q[1].delete();
      cmd_q[1].delete();
      rd_q[1].delete();
      #1;
      check_quiet(1, "midreset_b");
      repeat (2) @(posedge clk);
      #1;
      rst_n[1] = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("b3_busy_after_reset", 64'(busy[1]), 64'(0));
      step(1, 4'b1110, 4'b0010);
      step(1, 4'b0000, 4'b0000);

      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("gnt_q%0d_drained", d), 64'(gnt_q[d].size()), 64'(0));
         check($sformatf("cmd_q%0d_drained", d), 64'(cmd_q[d].size()), 64'(0));
         check($sformatf("rd_q%0d_drained", d), 64'(rd_q[d].size()), 64'(0));
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
